keypad_decoder: RTL and testbench

- Receiving end of the 4x4 keypad scan interface. The column sequencer drives one kpc line low at a time and holds that column while any row reads low.
- This block samples the kpc/kpr pair, synchronizes and debounces it, and maps the (row, col) position to a 4-bit key code.
- Each debounced press produces one event on a valid/ready handshake toward the application logic (toaster control FSM, 7-seg display).

---
 rtl/keypad_pkg.sv | 64 ++++++
 rtl/keypad_decoder_sync.sv | 23 ++
 rtl/keypad_decoder.sv | 174 +++++++++++++++++
 tb/tb_keypad_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key codes and decode helpers for the 4x4 keypad receiver.
// The optional auto-repeat feature in keypad_decoder is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } kp_state_t;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // True when exactly one of the four active-low lines is driven low.
    function automatic logic kp_one_low(input logic [3:0] lines);
        return (lines == 4'b0111) || (lines == 4'b1011) ||
               (lines == 4'b1101) || (lines == 4'b1110);
    endfunction

    // Index of the low line, counted from bit 3 (bit 3 -> 0, bit 0 -> 3).
    function automatic logic [1:0] kp_low_idx(input logic [3:0] lines);
        logic [1:0] idx;
        idx = 2'd0;
        case (lines)
            4'b0111: idx = 2'd0;
            4'b1011: idx = 2'd1;
            4'b1101: idx = 2'd2;
            4'b1110: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] kp_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            4'b11_11: code = KEY_D;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_decoder_sync.sv
// Two-flop synchronizer for asynchronous active-low keypad lines; resets to all-ones (nothing pressed).
module kp_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// 4x4 keypad receiver: synchronize, debounce, decode and hand off key events on valid/ready.
// Define KEYPAD_REPEAT_EN to emit auto-repeat events while a key stays held.
import keypad_pkg::*;

module keypad_decoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int CNT_W = $clog2(((DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                                  DEBOUNCE_CYCLES : REPEAT_CYCLES) + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpc,
    input  logic [3:0] kpr,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       kpr_sync;
    logic [3:0]       kpc_sync;
    logic             raw_valid;
    logic [3:0]       raw_code;
    kp_state_t        state_q;
    kp_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       cand_q;
    logic [3:0]       cand_d;
    logic             press_evt;
    logic             event_any;
    logic             accept;

    kp_sync #(.W(4)) u_sync_kpr (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (kpr),
        .q       (kpr_sync)
    );

    kp_sync #(.W(4)) u_sync_kpc (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (kpc),
        .q       (kpc_sync)
    );

    assign raw_valid = kp_one_low(kpr_sync) && kp_one_low(kpc_sync);
    assign raw_code  = kp_map(kp_low_idx(kpr_sync), kp_low_idx(kpc_sync));

    // Saturating increment so a stuck debounce can never wrap into a false terminal count.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        press_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (raw_valid) begin
                    cand_d  = raw_code;
                    cnt_d   = '0;
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!raw_valid || (raw_code != cand_q)) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_TC) begin
                    state_d   = PRESSED;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            // Any row still low counts as held, even if the column scanner moved on.
            PRESSED: begin
                if (kpr_sync == 4'b1111) begin
                    cnt_d   = '0;
                    state_d = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (kpr_sync != 4'b1111) begin
                    state_d = PRESSED;
                end else if (cnt_q == DEB_TC) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_down = (state_q == PRESSED) || (state_q == DEB_RELEASE);

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TC = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rep_q;
    logic [CNT_W-1:0] rep_d;
    logic             rep_evt;

    // Runs only while staying in PRESSED, so every entry (including from DEB_RELEASE) restarts it.
    always_comb begin
        rep_d   = '0;
        rep_evt = 1'b0;
        if ((state_q == PRESSED) && (state_d == PRESSED)) begin
            if (rep_q == REP_TC) begin
                rep_evt = 1'b1;
            end else begin
                rep_d = rep_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign event_any = press_evt || rep_evt;
`else
    assign event_any = press_evt;
`endif

    assign accept = key_valid && key_ready;

    // A new event arriving in the same cycle as an acceptance replaces the code without overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (event_any) begin
                if (!key_valid || accept) begin
                    key_code  <= cand_q;
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                key_valid <= 1'b0;
            end
            if (accept) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_decoder.sv
// Scoreboard bench for keypad_decoder with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16.
// Also covers the KEYPAD_REPEAT_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_keypad_decoder;

    logic       clk;
    logic       reset_n;
    logic [3:0] kpc;
    logic [3:0] kpr;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_down;
    logic       overrun;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    int         ev_t[$];

`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_EV = 4;
`else
    localparam int EXP_EV = 1;
`endif

    keypad_decoder #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .kpc       (kpc),
        .kpr       (kpr),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance n clock edges; inputs change and checks happen 2ns after each rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Each accepted event is matched against the oldest expected code.
    always @(negedge clk) begin
        if (reset_n && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got code %0h, expected no event (t=%0t)", key_code, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("event_code", {28'd0, key_code}, {28'd0, mon_exp});
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        kpc       = 4'b1011;
        kpr       = 4'b1101;
        key_ready = 1'b0;

        cyc(3);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_down", key_down, 0);
        chk("rst_overrun", overrun, 0);
        kpc     = 4'b1111;
        kpr     = 4'b1111;
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("idle_quiet", {key_valid, key_down, overrun}, 3'b000);
        end

        // Clean press of '8'
        kpc = 4'b1011;
        kpr = 4'b1101;
        exp_q.push_back(4'h8);
        cyc(6);
        chk("clean_not_yet", key_valid, 0);
        cyc(1);
        chk("clean_valid", key_valid, 1);
        chk("clean_code", key_code, 4'h8);
        chk("clean_down", key_down, 1);
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
        chk("clean_accepted", key_valid, 0);
        chk("clean_still_down", key_down, 1);
        kpr = 4'b1111;
        cyc(12);
        chk("clean_released", key_down, 0);

        // Bounce: 3 pressed, 1 open, then steady
        exp_q.push_back(4'h8);
        kpr = 4'b1101;
        cyc(3);
        kpr = 4'b1111;
        cyc(1);
        kpr = 4'b1101;
        cyc(6);
        chk("bounce_not_yet", key_valid, 0);
        cyc(1);
        chk("bounce_valid", key_valid, 1);
        chk("bounce_code", key_code, 4'h8);
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
        cyc(4);
        chk("bounce_single", key_valid, 0);
        kpr = 4'b1111;
        cyc(12);
        chk("bounce_released", key_down, 0);

        // Overrun: '*' pending, then '#' dropped
        exp_q.push_back(4'hE);
        kpc = 4'b0111;
        kpr = 4'b1110;
        cyc(10);
        chk("star_valid", key_valid, 1);
        chk("star_code", key_code, 4'hE);
        chk("star_no_overrun", overrun, 0);
        kpr = 4'b1111;
        cyc(12);
        kpc = 4'b1101;
        kpr = 4'b1110;
        cyc(10);
        chk("ovr_valid", key_valid, 1);
        chk("ovr_code_kept", key_code, 4'hE);
        chk("ovr_flag", overrun, 1);
        kpr = 4'b1111;
        cyc(12);
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
        chk("ovr_accepted", key_valid, 0);
        chk("ovr_cleared", overrun, 0);

        // Event and acceptance on the same edge: '1' pending, 'D' arrives
        exp_q.push_back(4'h1);
        kpc = 4'b0111;
        kpr = 4'b0111;
        cyc(10);
        kpr = 4'b1111;
        cyc(12);
        exp_q.push_back(4'hD);
        kpc = 4'b1110;
        kpr = 4'b1110;
        cyc(6);
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
        chk("same_edge_valid", key_valid, 1);
        chk("same_edge_code", key_code, 4'hD);
        chk("same_edge_no_ovr", overrun, 0);
        kpr = 4'b1111;
        cyc(12);
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;

        // Release glitch while held
        exp_q.push_back(4'h8);
        kpc = 4'b1011;
        kpr = 4'b1101;
        cyc(10);
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
        kpr = 4'b1111;
        cyc(2);
        kpr = 4'b1101;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("glitch_held", {key_down, key_valid}, 2'b10);
        end
        kpr = 4'b1111;
        cyc(12);
        chk("glitch_released", {key_down, key_valid}, 2'b00);

        // Asynchronous reset with an event pending and a key held
        kpr = 4'b1101;
        cyc(10);
        chk("pre_rst_valid", key_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", key_valid, 0);
        chk("async_rst_down", key_down, 0);
        kpr = 4'b1111;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);

        // Reset during press debounce
        kpr = 4'b1101;
        cyc(4);
        reset_n = 1'b0;
        cyc(2);
        kpr     = 4'b1111;
        reset_n = 1'b1;
        cyc(15);
        chk("mid_deb_no_event", {key_valid, key_down, overrun}, 3'b000);

        // Hold '5' with the consumer always ready
        key_ready = 1'b1;
        for (int i = 0; i < EXP_EV; i++) exp_q.push_back(4'h5);
        kpc = 4'b1011;
        kpr = 4'b1011;
        for (int c = 1; c <= 60; c++) begin
            cyc(1);
            if (key_valid) ev_t.push_back(c);
        end
        kpr = 4'b1111;
        chk("hold_event_count", ev_t.size(), EXP_EV);
        if (ev_t.size() > 0) chk("hold_first_latency", ev_t[0], 7);
        for (int i = 1; i < ev_t.size(); i++) chk("repeat_spacing", ev_t[i] - ev_t[i-1], 16);
        cyc(12);
        key_ready = 1'b0;
        chk("hold_released", key_down, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
